// File: rtl/tb_scheduler_pkg.sv
// Shared types and defaults for the Viterbi traceback scheduler.
// Holds the state width, default bank geometry and the job FSM encoding.
package tb_scheduler_pkg;

    localparam int unsigned WD_STATE  = 8;
    localparam int unsigned DEF_DEPTH = 8;
    localparam int unsigned DEF_NB    = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StInit   = 2'd1,
        StTrace  = 2'd2,
        StDecode = 2'd3
    } tb_state_e;

endpackage

// File: rtl/tb_scheduler_if.sv
// Signal bundle between the scheduler, the ACS write side and the TBU control pins.
// AW is the full {bank, col} survivor RAM address width.
interface tb_scheduler_if #(
    parameter int unsigned WS = 8,
    parameter int unsigned AW = 5
);
    logic          clr;
    logic          col_valid;
    logic [WS-1:0] best_state;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          tb_en;
    logic          tb_init;
    logic [WS-1:0] tb_init_state;
    logic          tb_hold;
    logic [AW-1:0] rd_addr;
    logic          busy;
    logic          overrun;

    modport master (
        output clr, col_valid, best_state,
        input  wr_en, wr_addr, tb_en, tb_init, tb_init_state, tb_hold, rd_addr, busy, overrun
    );

    modport slave (
        input  clr, col_valid, best_state,
        output wr_en, wr_addr, tb_en, tb_init, tb_init_state, tb_hold, rd_addr, busy, overrun
    );

endinterface

// File: rtl/tb_wr_ptr.sv
// Survivor column write pointer: {bank, col} counter, fill count and job request strobe.
// A job is requested on every bank completion once three banks have been filled.
module tb_wr_ptr #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NB    = 4,
    parameter int unsigned CW    = $clog2(DEPTH),
    parameter int unsigned BW    = $clog2(NB)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             col_valid_i,
    output logic [BW+CW-1:0] wr_addr_o,
    output logic [BW-1:0]    done_bank_o,
    output logic             job_req_o
);

    localparam logic [CW-1:0] LastCol = CW'(DEPTH - 1);

    logic [CW-1:0] wcol_q, wcol_d;
    logic [BW-1:0] wbank_q, wbank_d;
    logic [1:0]    fill_q, fill_d;
    logic          wrap;

    assign wrap = col_valid_i && (wcol_q == LastCol);

    always_comb begin
        wcol_d  = wcol_q;
        wbank_d = wbank_q;
        fill_d  = fill_q;
        if (clr_i) begin
            wcol_d  = '0;
            wbank_d = '0;
            fill_d  = '0;
        end else if (col_valid_i) begin
            // DEPTH and NB are powers of two, so both counters wrap naturally.
            wcol_d = wcol_q + 1'b1;
            if (wrap) begin
                wbank_d = wbank_q + 1'b1;
                if (fill_q != 2'd3) begin
                    fill_d = fill_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcol_q  <= '0;
            wbank_q <= '0;
            fill_q  <= '0;
        end else begin
            wcol_q  <= wcol_d;
            wbank_q <= wbank_d;
            fill_q  <= fill_d;
        end
    end

    assign wr_addr_o   = {wbank_q, wcol_q};
    assign done_bank_o = wbank_q;
    assign job_req_o   = wrap && !clr_i && (fill_d == 2'd3);

endmodule

// File: rtl/tb_scheduler.sv
// Sequences survivor RAM bank rotation and runs one INIT/TRACE/DECODE traceback job per bank.
// TBU pins decode only registered state, so no input reaches them combinationally.
module tb_scheduler
    import tb_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned NB    = DEF_NB,
    parameter int unsigned WS    = WD_STATE
) (
    input logic           CLOCK,
    input logic           Reset,
    tb_scheduler_if.slave bus
);

    localparam int unsigned   CW      = $clog2(DEPTH);
    localparam int unsigned   BW      = $clog2(NB);
    localparam logic [CW-1:0] LastCol = CW'(DEPTH - 1);

    tb_state_e     state_q, state_d;
    logic [BW-1:0] start_bank_q, start_bank_d;
    logic [WS-1:0] init_state_q, init_state_d;
    logic [CW-1:0] step_q, step_d;
    logic          overrun_q, overrun_d;
    logic [BW-1:0] done_bank;
    logic          job_req;
    logic [BW-1:0] rd_bank;
    logic [CW-1:0] rd_col;

    tb_wr_ptr #(
        .DEPTH (DEPTH),
        .NB    (NB),
        .CW    (CW),
        .BW    (BW)
    ) u_wr_ptr (
        .clk_i       (CLOCK),
        .rst_ni      (Reset),
        .clr_i       (bus.clr),
        .col_valid_i (bus.col_valid),
        .wr_addr_o   (bus.wr_addr),
        .done_bank_o (done_bank),
        .job_req_o   (job_req)
    );

    always_comb begin
        state_d      = state_q;
        start_bank_d = start_bank_q;
        init_state_d = init_state_q;
        step_d       = step_q;
        overrun_d    = overrun_q;
        if (bus.clr) begin
            state_d      = StIdle;
            start_bank_d = '0;
            init_state_d = '0;
            step_d       = '0;
            overrun_d    = 1'b0;
        end else begin
            // A request while a job runs is dropped; the running job continues untouched.
            if (job_req && (state_q != StIdle)) begin
                overrun_d = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (job_req) begin
                        start_bank_d = done_bank;
                        init_state_d = bus.best_state;
                        state_d      = StInit;
                    end
                end
                StInit: begin
                    step_d  = '0;
                    state_d = StTrace;
                end
                StTrace: begin
                    step_d = step_q + 1'b1;
                    if (step_q == LastCol) begin
                        step_d  = '0;
                        state_d = StDecode;
                    end
                end
                StDecode: begin
                    step_d = step_q + 1'b1;
                    if (step_q == LastCol) begin
                        step_d  = '0;
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            state_q      <= StIdle;
            start_bank_q <= '0;
            init_state_q <= '0;
            step_q       <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_bank_q <= start_bank_d;
            init_state_q <= init_state_d;
            step_q       <= step_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        rd_bank = start_bank_q;
        rd_col  = '0;
        unique case (state_q)
            StIdle:   rd_bank = '0;
            StInit:   rd_col  = LastCol;
            StTrace:  rd_col  = LastCol - step_q;
            StDecode: begin
                rd_bank = start_bank_q - 1'b1;
                rd_col  = LastCol - step_q;
            end
        endcase
    end

    assign bus.wr_en         = bus.col_valid;
    assign bus.tb_en         = (state_q != StIdle);
    assign bus.busy          = (state_q != StIdle);
    assign bus.tb_init       = (state_q == StInit);
    assign bus.tb_hold       = (state_q == StDecode);
    assign bus.tb_init_state = init_state_q;
    assign bus.rd_addr       = {rd_bank, rd_col};
    assign bus.overrun       = overrun_q;

endmodule

// File: doc/tb_scheduler.md
Name: tb_scheduler

Overview:
- Controller that sequences the survivor memory and the traceback unit of the Viterbi decoder.
- Keeps the write pointer for survivor columns coming from the ACS array.
- Rotates the survivor RAM banks and launches one traceback job per completed bank.
- During each job it drives the TBU control pins: TB_EN, Init, InitState, Hold and the read address.

Parameters:
- DEPTH, 8, columns per bank (traceback depth per window); power of 2, at least 2.
- NB, 4, number of survivor RAM banks; power of 2, at least 4.
- WS, `WD_STATE (8), state width.
- CW, log2(DEPTH), column address width.
- BW, log2(NB), bank address width.

Ports:
- CLOCK  in  1  system clock; all logic on posedge.
- Reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous soft clear; same effect as reset.
- col_valid  in  1  ACS presents a survivor column this cycle.
- best_state  in  WS  ACS best-metric state, valid with col_valid.
- wr_en  out  1  survivor RAM write strobe.
- wr_addr  out  BW+CW  survivor RAM write address, {bank, col}.
- tb_en  out  1  TBU enable.
- tb_init  out  1  TBU Init pulse.
- tb_init_state  out  WS  TBU InitState.
- tb_hold  out  1  TBU Hold; 1 marks decoded-output steps.
- rd_addr  out  BW+CW  survivor RAM read address, {bank, col}.
- busy  out  1  traceback job in progress.
- overrun  out  1  sticky; a job request was dropped.

Behaviour:
- Reset or clr, all registered state cleared:
  - wbank=0, wcol=0, fill_cnt=0, state=IDLE, start_bank=0, init_state=0, step=0, overrun=0.
  - Resulting outputs: tb_en=0, tb_init=0, tb_hold=0, busy=0, rd_addr=0, tb_init_state=0.
  - Reset asserted mid-job aborts the job immediately; no partial outputs afterwards.
- Write side:
  - wr_en = col_valid (combinational); wr_addr = {wbank, wcol} (registered).
  - On col_valid: wcol increments.
  - On col_valid with wcol==DEPTH-1:
    - wcol←0, wbank←wbank+1 mod NB.
    - fill_cnt saturating-increments to 3.
    - Bank-complete event for bank c = old wbank.
- Job request: a bank-complete event occurs and the updated fill_cnt is 3 (third and every later completed bank).
  - If state==IDLE: latch start_bank←c and init_state←best_state (same cycle); next state INIT.
  - If state!=IDLE: request dropped and overrun←1 (sticky until reset/clr); the running job is unaffected.
- FSM, one step per cycle:
  - IDLE: tb_en=0, busy=0.
  - INIT, 1 cycle:
    - tb_en=1, tb_init=1, tb_init_state=init_state, tb_hold=0, busy=1.
    - rd_addr={start_bank, DEPTH-1}.
    - Next: TRACE with step=0.
  - TRACE, DEPTH cycles, k=0..DEPTH-1:
    - tb_en=1, tb_hold=0.
    - rd_addr={start_bank, DEPTH-1-k}.
    - After k=DEPTH-1: DECODE with step=0.
  - DECODE, DEPTH cycles:
    - tb_en=1, tb_hold=1.
    - rd_addr={start_bank-1 mod NB, DEPTH-1-k}.
    - After k=DEPTH-1: IDLE.
- tb_init_state holds init_state in all states; tb_init is 1 only in INIT.
- Job length 1+2·DEPTH cycles (17 at defaults).
- Bank safety:
  - During a job the written bank is start_bank+1 or +2; the read banks are start_bank and start_bank-1.
  - With NB≥4 writes never alias reads while no overrun occurs.
- Throughput:
  - Sustained col_valid faster than one per (1+2·DEPTH)/DEPTH cycles causes overrun.
  - Overrun is an error flag only; writes continue regardless.
- All outputs except wr_en are registered; no combinational path from inputs to the TBU pins.

Decomposition:
- Shared package/params.v: WD_STATE, state encodings IDLE/INIT/TRACE/DECODE (2-bit), DEPTH/NB defaults.
- One natural sub-module: tb_wr_ptr.
  - Contains the column/bank write counter, fill_cnt and bank-complete strobe.
  - The FSM stays in tb_scheduler.

Test Plan:
- Reset: Reset=0 with col_valid toggling -> all outputs 0, wr_addr=0; release Reset, 8 col_valid -> wr_addr 0..7, then wbank=1.
- First jobs:
  - 24 back-to-back col_valid, best_state=0x5A on the 24th -> no job after banks 0 and 1.
  - After bank 2 completes: tb_init=1 one cycle with tb_init_state=0x5A and rd_addr={2,7}.
  - Then 8 TRACE cycles, rd_addr {2,7}..{2,0}, tb_hold=0.
  - Then 8 DECODE cycles, rd_addr {1,7}..{1,0}, tb_hold=1.
  - Then busy=0.
- Sustained rate: col_valid every 3rd cycle for 10 banks -> one job per bank from bank 2 on, overrun stays 0, wr_addr never equals rd_addr while tb_en=1.
- Overrun: continuous col_valid for 5 banks -> bank-3 completion arrives 8 cycles into the bank-2 job, so overrun=1 and that request is dropped; the bank-2 job still finishes all 17 cycles.
- Reset mid-job: assert Reset during DECODE step 3 -> tb_en, tb_hold and busy go 0 immediately; after release, no job until 3 new banks complete.
- Soft clear: clr=1 one cycle while overrun=1 and busy=1 -> next cycle overrun=0, busy=0, wr_addr=0.
